uart_rx_fsm: RTL and testbench

Frame-sequencing controller for the UART receiver. Watches the serial line, enables and reads back the edge/bit counter, and issues one-cycle strobes to the data sampler, deserializer and start/parity/stop checkers. Qualifies each received frame as a single `data_valid` or `frame_err` pulse. Sits between the RX line synchroniser and the RX datapath, in the UART clock domain.

---
 rtl/uart_rx_pkg.sv | 35 +++
 rtl/uart_rx_fsm_if.sv | 47 ++++
 rtl/rx_sample_point.sv | 41 ++++
 rtl/uart_rx_fsm.sv | 135 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Package  : uart_rx_pkg
// Purpose  : Shared state encoding and sample-point offsets for the UART RX
//            frame-sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

  // State encoding, kept as explicit constants so the width is fixed.
  localparam logic [2:0] C_ST_IDLE   = 3'd0;
  localparam logic [2:0] C_ST_START  = 3'd1;
  localparam logic [2:0] C_ST_DATA   = 3'd2;
  localparam logic [2:0] C_ST_PARITY = 3'd3;
  localparam logic [2:0] C_ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = C_ST_IDLE,
    ST_START  = C_ST_START,
    ST_DATA   = C_ST_DATA,
    ST_PARITY = C_ST_PARITY,
    ST_STOP   = C_ST_STOP
  } state_t;

  // Check strobes fire two edges after mid-bit, once the sampler's
  // three-sample majority window has closed.
  localparam logic [4:0] C_CHK_OFS       = 5'd2;
  // The stop bit is abandoned one edge after its check so that a
  // following start bit can be caught without losing a cycle.
  localparam logic [4:0] C_STOP_EXIT_OFS = 5'd3;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fsm_if.sv
// ============================================================================
// Interface : uart_rx_fsm_if
// Purpose   : Signal bundle between the RX frame controller (slave) and the
//             line synchroniser / counter / checkers around it (master).
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_fsm_if;

  logic       rx_in;
  logic       par_en;
  logic [4:0] prescale;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;

  logic       cnt_enable;
  logic       dat_samp_en;
  logic       deser_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;
  logic       frame_err;

  modport slave (
    input  rx_in, par_en, prescale, edge_cnt, bit_cnt,
    input  strt_glitch, par_err, stp_err,
    output cnt_enable, dat_samp_en, deser_en,
    output strt_chk_en, par_chk_en, stp_chk_en,
    output data_valid, frame_err
  );

  modport master (
    output rx_in, par_en, prescale, edge_cnt, bit_cnt,
    output strt_glitch, par_err, stp_err,
    input  cnt_enable, dat_samp_en, deser_en,
    input  strt_chk_en, par_chk_en, stp_chk_en,
    input  data_valid, frame_err
  );

endinterface

`default_nettype wire

// File: rtl/rx_sample_point.sv
// ============================================================================
// Module   : rx_sample_point
// Purpose  : Combinational decode of the mid-bit sample window, check point,
//            stop-exit point and bit end from prescale and edge count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_sample_point
  import uart_rx_pkg::*;
(
  input  wire logic [4:0] i_prescale,
  input  wire logic [4:0] i_edge_cnt,
  output logic            o_at_chk,
  output logic            o_at_exit,
  output logic            o_at_end,
  output logic            o_in_win
);

  logic [4:0] w_half;
  logic [4:0] w_chk;
  logic [4:0] w_exit;
  logic       w_unused_lsb;

  // Prescale is always even, so its LSB carries no information.
  assign w_unused_lsb = i_prescale[0];

  // Decode the fixed points within one bit period.
  always_comb begin
    w_half    = {1'b0, i_prescale[4:1]};
    w_chk     = w_half + C_CHK_OFS;
    w_exit    = w_half + C_STOP_EXIT_OFS;
    o_at_chk  = (i_edge_cnt == w_chk);
    o_at_exit = (i_edge_cnt == w_exit);
    o_at_end  = (i_edge_cnt == i_prescale);
    o_in_win  = (i_edge_cnt >= (w_half - 5'd1)) && (i_edge_cnt <= (w_half + 5'd1));
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fsm.sv
// ============================================================================
// Module   : uart_rx_fsm
// Purpose  : UART RX frame-sequencing controller. Steps IDLE/START/DATA/
//            PARITY/STOP, drives the edge/bit counter enable, sampler window,
//            deserializer and checker strobes, and qualifies each frame with
//            a single data_valid or frame_err pulse.
// Config   : UART_RX_PARITY_EN - when defined, the PARITY state and the
//            parity error flag are built; otherwise par_en/par_err are
//            ignored and every frame goes DATA -> STOP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  wire logic    clk,
  input  wire logic    rest,
  uart_rx_fsm_if.slave bus
);

  localparam logic [3:0] C_LAST_BIT = 4'(DATA_WIDTH);

  state_t r_state;
  logic   r_data_valid;
  logic   r_frame_err;
`ifdef UART_RX_PARITY_EN
  logic   r_err;
`endif

  logic w_at_chk;
  logic w_at_exit;
  logic w_at_end;
  logic w_in_win;
  logic w_cnt_enable;

  rx_sample_point u_sample_point (
    .i_prescale (bus.prescale),
    .i_edge_cnt (bus.edge_cnt),
    .o_at_chk   (w_at_chk),
    .o_at_exit  (w_at_exit),
    .o_at_end   (w_at_end),
    .o_in_win   (w_in_win)
  );

  // Frame state, parity error flag and registered result pulses.
  always_ff @(posedge clk) begin
    if (rest) begin
      r_state      <= ST_IDLE;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_err        <= 1'b0;
`endif
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
`ifdef UART_RX_PARITY_EN
          r_err <= 1'b0;
`endif
          if (!bus.rx_in) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_at_end) begin
            r_state <= bus.strt_glitch ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_at_end && (bus.bit_cnt == C_LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
            r_state <= bus.par_en ? ST_PARITY : ST_STOP;
`else
            r_state <= ST_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_at_end) begin
            if (bus.par_err) begin
              r_err <= 1'b1;
            end
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          // Leave mid stop bit; stp_err is valid here, one cycle after its strobe.
          if (w_at_exit) begin
            r_state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
            if (bus.stp_err || r_err) begin
`else
            if (bus.stp_err) begin
`endif
              r_frame_err  <= 1'b1;
            end else begin
              r_data_valid <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Counter enable and check strobes decoded from the state register.
  assign w_cnt_enable    = (r_state != ST_IDLE);
  assign bus.cnt_enable  = w_cnt_enable;
  assign bus.dat_samp_en = w_cnt_enable && w_in_win;
  assign bus.strt_chk_en = (r_state == ST_START) && w_at_chk && (bus.bit_cnt == 4'd0);
  assign bus.deser_en    = (r_state == ST_DATA) && w_at_chk;
  assign bus.stp_chk_en  = (r_state == ST_STOP) && w_at_chk;
  assign bus.data_valid  = r_data_valid;
  assign bus.frame_err   = r_frame_err;

`ifdef UART_RX_PARITY_EN
  assign bus.par_chk_en  = (r_state == ST_PARITY) && w_at_chk;
`else
  logic w_unused_par;
  assign w_unused_par    = bus.par_en ^ bus.par_err;
  assign bus.par_chk_en  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
// ============================================================================
// Module   : tb_uart_rx_fsm
// Purpose  : Scoreboard bench for uart_rx_fsm. A behavioural edge/bit counter
//            and registered checker stubs surround the DUT; each frame pushes
//            its expected strobe sequence and result pulse into a queue that a
//            negedge monitor pops whenever the DUT raises a strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fsm;

  localparam int DW = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  typedef enum int {K_STRT, K_DESER, K_PAR, K_STP, K_DV, K_FE} kind_e;
  typedef struct {
    kind_e kind;
    int    e_cnt;
    int    b_cnt;
  } ev_t;

  logic clk = 1'b0;
  logic rest;
  logic cfg_glitch, cfg_parerr, cfg_stperr;
  logic [4:0] r_edge = 5'd0;
  logic [3:0] r_bit  = 4'd0;
  ev_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int mon_half;
  logic mon_samp;

  always #5 clk = ~clk;

  uart_rx_fsm_if bus ();

  uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rest (rest),
    .bus  (bus)
  );

  // Edge/bit counter: cleared while disabled, wraps edge to 1 at prescale.
  always @(posedge clk) begin
    if (rest || !bus.cnt_enable) begin
      r_edge <= 5'd0;
      r_bit  <= 4'd0;
    end else if (r_edge == bus.prescale) begin
      r_edge <= 5'd1;
      r_bit  <= r_bit + 4'd1;
    end else begin
      r_edge <= r_edge + 5'd1;
    end
  end
  assign bus.edge_cnt = bus.cnt_enable ? r_edge : 5'd0;
  assign bus.bit_cnt  = bus.cnt_enable ? r_bit  : 4'd0;

  // Checker stubs: result registered on the cycle of each check strobe.
  always @(posedge clk) begin
    if (rest) begin
      bus.strt_glitch <= 1'b0;
      bus.par_err     <= 1'b0;
      bus.stp_err     <= 1'b0;
    end else begin
      if (bus.strt_chk_en) bus.strt_glitch <= cfg_glitch;
      if (bus.par_chk_en)  bus.par_err     <= cfg_parerr;
      if (bus.stp_chk_en)  bus.stp_err     <= cfg_stperr;
    end
  end

  task automatic check_eq(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_ev(input kind_e k, input int e, input int b);
    ev_t ev;
    ev.kind  = k;
    ev.e_cnt = e;
    ev.b_cnt = b;
    exp_q.push_back(ev);
  endtask

  task automatic observe(input kind_e k, input int e, input int b);
    ev_t x;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got edge=%0d bit=%0d, required no event", k.name(), e, b);
    end else begin
      x = exp_q.pop_front();
      if (x.kind != k ||
          (k != K_DV && k != K_FE && (x.e_cnt != e || x.b_cnt != b))) begin
        errors++;
        $display("FAIL event: got %s edge=%0d bit=%0d, required %s edge=%0d bit=%0d",
                 k.name(), e, b, x.kind.name(), x.e_cnt, x.b_cnt);
      end
    end
  endtask

  // Monitor: sampler window check every cycle, strobes popped from the queue.
  always @(negedge clk) begin
    if (!rest) begin
      mon_half = int'(bus.prescale) >> 1;
      mon_samp = bus.cnt_enable && (int'(bus.edge_cnt) >= mon_half - 1) &&
                 (int'(bus.edge_cnt) <= mon_half + 1);
      checks++;
      if (bus.dat_samp_en !== mon_samp) begin
        errors++;
        $display("FAIL dat_samp_en: got %b, required %b at edge=%0d", bus.dat_samp_en, mon_samp, bus.edge_cnt);
      end
      if (bus.strt_chk_en) observe(K_STRT,  int'(bus.edge_cnt), int'(bus.bit_cnt));
      if (bus.deser_en)    observe(K_DESER, int'(bus.edge_cnt), int'(bus.bit_cnt));
      if (bus.par_chk_en)  observe(K_PAR,   int'(bus.edge_cnt), int'(bus.bit_cnt));
      if (bus.stp_chk_en)  observe(K_STP,   int'(bus.edge_cnt), int'(bus.bit_cnt));
      if (bus.data_valid)  observe(K_DV, 0, 0);
      if (bus.frame_err)   observe(K_FE, 0, 0);
    end
  end

  function automatic int out_vec();
    return int'({bus.cnt_enable, bus.dat_samp_en, bus.deser_en, bus.strt_chk_en,
                 bus.par_chk_en, bus.stp_chk_en, bus.data_valid, bus.frame_err});
  endfunction

  function automatic int exp_len(input int ps, input bit pe, input bit gl);
    if (gl) return ps + 1;
    return (ps + 1) + DW * ps + ((pe && PAR_BUILT) ? ps : 0) + (ps / 2 + 3);
  endfunction

  task automatic push_frame(input int ps, input bit pe, input bit gl, input bit pr, input bit st);
    int  chk;
    bit  par;
    chk = ps / 2 + 2;
    par = pe && PAR_BUILT;
    push_ev(K_STRT, chk, 0);
    if (!gl) begin
      for (int i = 1; i <= DW; i++) push_ev(K_DESER, chk, i);
      if (par) push_ev(K_PAR, chk, DW + 1);
      push_ev(K_STP, chk, par ? DW + 2 : DW + 1);
      if (st || (par && pr)) push_ev(K_FE, 0, 0);
      else                   push_ev(K_DV, 0, 0);
    end
  endtask

  // armed: rx_in already low from the previous frame; chain: drop rx_in at
  // this frame's stop check so the next start bit follows immediately.
  task automatic run_frame(input int ps, input bit pe, input bit gl, input bit pr,
                           input bit st, input bit armed, input bit chain);
    int len;
    int n;
    bit held;
    bus.prescale = 5'(ps);
    bus.par_en   = pe;
    cfg_glitch   = gl;
    cfg_parerr   = pr;
    cfg_stperr   = st;
    push_frame(ps, pe, gl, pr, st);
    if (!armed) begin
      @(posedge clk); #1;
      bus.rx_in = 1'b0;
    end
    @(posedge clk); #1;
    check_eq(armed ? "rearm_latency" : "start_latency", int'(bus.cnt_enable), 1);
    len  = 1;
    n    = 0;
    held = 1'b0;
    while (bus.cnt_enable && n < 4000) begin
      if (chain && bus.stp_chk_en) begin
        bus.rx_in = 1'b0;
        held = 1'b1;
      end else if (!held && len >= (gl ? 2 : 1)) begin
        bus.rx_in = 1'b1;
      end
      @(posedge clk); #1;
      n++;
      if (bus.cnt_enable) len++;
    end
    if (n >= 4000) begin
      errors++;
      $display("FAIL frame_timeout: got busy after %0d cycles, required idle", n);
    end
    check_eq("frame_len", len, exp_len(ps, pe, gl));
  endtask

  task automatic drain(input string name);
    @(negedge clk); #1;
    check_eq(name, exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    rest         = 1'b1;
    bus.rx_in    = 1'b1;
    bus.prescale = 5'd8;
    bus.par_en   = 1'b0;
    cfg_glitch   = 1'b0;
    cfg_parerr   = 1'b0;
    cfg_stperr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs", out_vec(), 0);
    rest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("idle_outputs", out_vec(), 0);

    // Good frame, no parity, prescale 8.
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("drain_good8");
    // Parity error at prescale 16 (parity state only when built in).
    run_frame(16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain("drain_parerr16");
    // Good parity frame: error flag from the previous frame must not linger.
    run_frame(10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("drain_pargood10");
    // Stop error.
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    drain("drain_stperr8");
    // Start glitch: only the start check, back to idle at edge 8.
    run_frame(8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("drain_glitch");
    // Back-to-back frames.
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_frame(8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain("drain_b2b");

    // Reset in the middle of DATA: strobes up to bit 3 only, no result pulse.
    bus.prescale = 5'd8;
    bus.par_en   = 1'b0;
    cfg_glitch   = 1'b0;
    cfg_stperr   = 1'b0;
    push_ev(K_STRT, 6, 0);
    for (int i = 1; i <= 3; i++) push_ev(K_DESER, 6, i);
    @(posedge clk); #1;
    bus.rx_in = 1'b0;
    @(posedge clk); #1;
    bus.rx_in = 1'b1;
    n = 0;
    while (bus.bit_cnt != 4'd4 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("reach_bit4", int'(bus.bit_cnt), 4);
    rest = 1'b1;
    @(posedge clk); #1;
    check_eq("reset_mid_data_outputs", out_vec(), 0);
    rest = 1'b0;
    drain("drain_reset_mid");
    repeat (3) @(posedge clk);
    check_eq("no_pulse_after_abort", exp_q.size(), 0);

    // Normal frame afterwards at the largest prescale.
    run_frame(30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain("drain_good30");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
